mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Parametrised memory-stage controller. It sits between the execute stage and an external data_cache instance, and connects to the memory controller (MC) through separate evict and fill handshakes. Over the previous memory-stage design it adds:
- byte, half-word, word and double-word access sizes, with lane merge on writes and sign/zero extension on reads;
- misalignment detection;
- a registered dataValid output;
- a bounded refill-retry counter with a sticky fatal-error flag.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, cache word width; legal values 32 or 64
BLK_W, 512, cache block width; a multiple of DATA_W
MAX_RETRY, 2, number of refills allowed per request before fatal error

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
memRead  in  1  read request; sampled in IDLE
memWrite  in  1  write request; sampled in IDLE
accSize  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64)
accSigned  in  1  sign-extend read result
addr  in  ADDR_W  byte address
wrData  in  DATA_W  store data, right-aligned
memoryOut  out  DATA_W  registered read result
dataValid  out  1  one-cycle pulse: access complete
stall  out  1  pipeline stall
misalignErr  out  1  one-cycle pulse: request rejected
fatalErr  out  1  sticky: refill retries exhausted
cacheEn, cacheRd, cacheWr, cacheLd  out  1 each  cache controls
cacheAddr  out  ADDR_W  latched request address
cacheDataIn  out  DATA_W  lane-replicated store data
cacheByteEn  out  DATA_W/8  store byte lanes
cacheBlkIn  out  BLK_W  fill block, equal to mcDataIn
cacheDataOut  in  DATA_W  cache read word
cacheHit, cacheMiss, cacheEvict  in  1 each  cache status
cacheBlkOut  in  BLK_W  victim block
mcEvict  out  1  evict request, held until evictDone
mcDataOut  out  BLK_W  victim block, equal to cacheBlkOut during EVICT
evictDone  in  1  MC evict complete
mcReq  out  1  fill request, held until mcDataValid
mcReqAddr  out  ADDR_W  block-aligned address; low log2(BLK_W/8) bits zero
mcDataValid  in  1  fill data valid this cycle
mcDataIn  in  BLK_W  fill block

Behaviour:
Reset:
- rst low: state IDLE; every output 0; request latches and retry counter cleared.
- rst asserted mid-operation aborts immediately; no MC handshake completes.

Request acceptance in IDLE:
- A request is memRead XOR memWrite.
- A request with fatalErr=0 is checked for alignment. Misaligned when: half with addr[0]=1; word with addr[1:0]!=0; dword with addr[2:0]!=0; or accSize=11 when DATA_W=32.
- Misaligned request: misalignErr pulses the next cycle, no cache access, state stays IDLE.
- Aligned request: latch addr, wrData, size, signed and op; clear retry counter; go to LOOKUP.
- memRead and memWrite both high: treated as misaligned.
- While fatalErr=1, requests are ignored.

stall = (state != IDLE) OR (IDLE and an aligned request is presented).

State machine:
- LOOKUP:
  - Drives cacheEn=1, cacheRd or cacheWr, cacheAddr.
  - Store: cacheByteEn selects lanes addr[log2(DATA_W/8)-1:0] for 1/2/4/8 bytes; cacheDataIn replicates wrData.
  - cacheHit → IDLE. A read also registers the extracted, extended lane into memoryOut. dataValid pulses the cycle after the hit.
  - Miss with cacheEvict → EVICT; miss without → LOAD.
- EVICT:
  - Drives cacheEn, cacheAddr, mcEvict=1, mcDataOut=cacheBlkOut.
  - evictDone → LOAD.
- LOAD:
  - Drives mcReq=1 and mcReqAddr.
  - In the cycle mcDataValid=1, drives cacheEn=1, cacheLd=1, cacheBlkIn=mcDataIn; → FILL.
- FILL:
  - One settle cycle; retry counter +1; → LOOKUP.
- A miss in LOOKUP when the retry counter equals MAX_RETRY: set fatalErr, go to IDLE, no dataValid.

Hit latency: 2 cycles from request to dataValid.

Read extension:
- Unsigned reads zero-extend.
- Signed reads replicate the top bit of the accessed size.
- A dword access uses the full width.

memoryOut holds its value until the next completed read.

Test Plan:
- Read hit: word read at 0x104, cacheHit=1 and cacheDataOut=0xDEADBEEF in LOOKUP → dataValid and memoryOut=0xDEADBEEF 2 cycles after the request; stall high for exactly 2 cycles.
- Signed byte read at 0x103, cacheDataOut=0x80000000 → memoryOut=0xFFFFFF80; the same access unsigned → 0x00000080.
- Write miss with evict at 0x2044: mcEvict held through 3 cycles of evictDone=0. Then mcReq with mcReqAddr=0x2040, mcDataValid after 5 cycles, cacheLd pulses. Re-LOOKUP hits; a half write at 0x2046 drives cacheByteEn=4'b1100.
- Misaligned: half read at 0x101, then memRead and memWrite together → misalignErr pulse each time, cacheEn never asserted, state stays IDLE.
- Retry exhaustion: cacheHit held 0 with MAX_RETRY=2 → three LOOKUPs, two fills, then fatalErr=1; a subsequent request is ignored; fatalErr clears only on rst low.
- Reset mid-LOAD: rst low while mcReq=1 → all outputs 0 asynchronously; after release a new read completes normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller between the execute stage, a data cache and the
// memory controller. Handles sized accesses (byte/half/word/dword), store
// lane merge, load extension, misalignment rejection and bounded refill
// retries with a sticky fatal-error flag.
module mem_stage_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BLK_W     = 512,
  parameter int MAX_RETRY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic [1:0]          accSize,
  input  logic                accSigned,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wrData,
  output logic [DATA_W-1:0]   memoryOut,
  output logic                dataValid,
  output logic                stall,
  output logic                misalignErr,
  output logic                fatalErr,
  output logic                cacheEn,
  output logic                cacheRd,
  output logic                cacheWr,
  output logic                cacheLd,
  output logic [ADDR_W-1:0]   cacheAddr,
  output logic [DATA_W-1:0]   cacheDataIn,
  output logic [DATA_W/8-1:0] cacheByteEn,
  output logic [BLK_W-1:0]    cacheBlkIn,
  input  logic [DATA_W-1:0]   cacheDataOut,
  input  logic                cacheHit,
  input  logic                cacheMiss,
  input  logic                cacheEvict,
  input  logic [BLK_W-1:0]    cacheBlkOut,
  output logic                mcEvict,
  output logic [BLK_W-1:0]    mcDataOut,
  input  logic                evictDone,
  output logic                mcReq,
  output logic [ADDR_W-1:0]   mcReqAddr,
  input  logic                mcDataValid,
  input  logic [BLK_W-1:0]    mcDataIn
);

  localparam int NB      = DATA_W / 8;
  localparam int OFF_W   = $clog2(NB);
  localparam int BLK_OFF = $clog2(BLK_W / 8);
  localparam int RET_W   = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    EVICT,
    LOAD,
    FILL
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic              wr_op_q;
  logic [RET_W-1:0]  retry_q;

  logic              req_any;
  logic              req_both;
  logic              addr_bad;
  logic              good_req;
  logic              bad_req;
  logic              retry_exhausted;

  logic [OFF_W-1:0]  lane_off;
  logic [DATA_W-1:0] lane_shifted;
  logic [DATA_W-1:0] ext_mask;
  logic              ext_top;
  logic [DATA_W-1:0] read_ext;
  logic [NB-1:0]     be_base;
  logic [DATA_W-1:0] rep_data;
  logic [ADDR_W-1:0] blk_addr;

  // Classify the request presented in IDLE: a single op that is naturally
  // aligned is accepted, anything else (including both ops at once) is rejected.
  always_comb begin
    req_any  = (memRead | memWrite) & ~fatalErr;
    req_both = memRead & memWrite;
    addr_bad = 1'b0;
    case (accSize)
      2'b00: addr_bad = 1'b0;
      2'b01: addr_bad = addr[0];
      2'b10: addr_bad = (addr[1:0] != 2'b00);
      default: addr_bad = (DATA_W == 32) || (addr[2:0] != 3'b000);
    endcase
    good_req = req_any & ~req_both & ~addr_bad;
    bad_req  = req_any & (req_both | addr_bad);
  end

  assign retry_exhausted = (retry_q == RET_W'(MAX_RETRY));
  assign lane_off        = addr_q[OFF_W-1:0];
  assign blk_addr        = {addr_q[ADDR_W-1:BLK_OFF], {BLK_OFF{1'b0}}};

  // Pull the addressed lane down to bit 0 and extend it to the full word.
  always_comb begin
    lane_shifted = cacheDataOut >> {lane_off, 3'b000};
    ext_mask     = '1;
    ext_top      = 1'b0;
    case (size_q)
      2'b00: begin
        ext_mask = DATA_W'(8'hFF);
        ext_top  = lane_shifted[7];
      end
      2'b01: begin
        ext_mask = DATA_W'(16'hFFFF);
        ext_top  = lane_shifted[15];
      end
      2'b10: begin
        ext_mask = DATA_W'(32'hFFFF_FFFF);
        ext_top  = lane_shifted[31];
      end
      default: begin
        ext_mask = '1;
        ext_top  = 1'b0;
      end
    endcase
    read_ext = lane_shifted & ext_mask;
    if (sgn_q && ext_top) begin
      read_ext = read_ext | ~ext_mask;
    end
  end

  // Build store byte lanes and replicate the store data across every lane
  // group so the cache only has to honour the byte enables.
  always_comb begin
    be_base  = '0;
    rep_data = '0;
    case (size_q)
      2'b00:   be_base = NB'(8'h01);
      2'b01:   be_base = NB'(8'h03);
      2'b10:   be_base = NB'(8'h0F);
      default: be_base = '1;
    endcase
    for (int i = 0; i < NB; i++) begin
      case (size_q)
        2'b00:   rep_data[i*8 +: 8] = wr_q[7:0];
        2'b01:   rep_data[i*8 +: 8] = wr_q[(i % 2)*8 +: 8];
        2'b10:   rep_data[i*8 +: 8] = wr_q[(i % 4)*8 +: 8];
        default: rep_data[i*8 +: 8] = wr_q[(i % 8)*8 +: 8];
      endcase
    end
  end

  // Next-state logic and per-state cache / memory-controller strobes.
  always_comb begin
    next_state  = state;
    cacheEn     = 1'b0;
    cacheRd     = 1'b0;
    cacheWr     = 1'b0;
    cacheLd     = 1'b0;
    cacheAddr   = '0;
    cacheDataIn = '0;
    cacheByteEn = '0;
    cacheBlkIn  = '0;
    mcEvict     = 1'b0;
    mcDataOut   = '0;
    mcReq       = 1'b0;
    mcReqAddr   = '0;
    case (state)
      IDLE: begin
        if (good_req) begin
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        cacheEn   = 1'b1;
        cacheRd   = ~wr_op_q;
        cacheWr   = wr_op_q;
        cacheAddr = addr_q;
        if (wr_op_q) begin
          cacheDataIn = rep_data;
          cacheByteEn = be_base << lane_off;
        end
        if (cacheHit) begin
          next_state = IDLE;
        end else if (cacheMiss) begin
          if (retry_exhausted) begin
            next_state = IDLE;
          end else if (cacheEvict) begin
            next_state = EVICT;
          end else begin
            next_state = LOAD;
          end
        end
      end
      EVICT: begin
        cacheEn   = 1'b1;
        cacheAddr = addr_q;
        mcEvict   = 1'b1;
        mcDataOut = cacheBlkOut;
        if (evictDone) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        mcReq     = 1'b1;
        mcReqAddr = blk_addr;
        if (mcDataValid) begin
          cacheEn    = 1'b1;
          cacheLd    = 1'b1;
          cacheAddr  = addr_q;
          cacheBlkIn = mcDataIn;
          next_state = FILL;
        end
      end
      FILL: begin
        next_state = LOOKUP;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Stall while busy, and in IDLE as soon as an acceptable request shows up;
  // held low while reset is asserted.
  always_comb begin
    stall = rst && ((state != IDLE) || good_req);
  end

  // State register, request latches, retry counter and registered status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wr_q        <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      wr_op_q     <= 1'b0;
      retry_q     <= '0;
      memoryOut   <= '0;
      dataValid   <= 1'b0;
      misalignErr <= 1'b0;
      fatalErr    <= 1'b0;
    end else begin
      state       <= next_state;
      dataValid   <= (state == LOOKUP) && cacheHit;
      misalignErr <= (state == IDLE) && bad_req;
      if (state == IDLE && good_req) begin
        addr_q  <= addr;
        wr_q    <= wrData;
        size_q  <= accSize;
        sgn_q   <= accSigned;
        wr_op_q <= memWrite;
        retry_q <= '0;
      end
      if (state == FILL) begin
        retry_q <= retry_q + RET_W'(1);
      end
      if (state == LOOKUP && cacheHit && !wr_op_q) begin
        memoryOut <= read_ext;
      end
      if (state == LOOKUP && !cacheHit && cacheMiss && retry_exhausted) begin
        fatalErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl (DATA_W=32, BLK_W=512, MAX_RETRY=2).
// Tests run in a fixed order; some expectations rely on earlier reads.
module tb_mem_stage_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         memRead, memWrite;
  logic [1:0]   accSize;
  logic         accSigned;
  logic [31:0]  addr;
  logic [31:0]  wrData;
  logic [31:0]  memoryOut;
  logic         dataValid, stall, misalignErr, fatalErr;
  logic         cacheEn, cacheRd, cacheWr, cacheLd;
  logic [31:0]  cacheAddr;
  logic [31:0]  cacheDataIn;
  logic [3:0]   cacheByteEn;
  logic [511:0] cacheBlkIn;
  logic [31:0]  cacheDataOut;
  logic         cacheHit, cacheMiss, cacheEvict;
  logic [511:0] cacheBlkOut;
  logic         mcEvict;
  logic [511:0] mcDataOut;
  logic         evictDone;
  logic         mcReq;
  logic [31:0]  mcReqAddr;
  logic         mcDataValid;
  logic [511:0] mcDataIn;

  int checks = 0;
  int passed = 0;

  localparam logic [511:0] VICTIM = {16{32'hCAFEF00D}};
  localparam logic [511:0] FILLBLK = {16{32'h13579BDF}};

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst),
    .memRead(memRead), .memWrite(memWrite), .accSize(accSize),
    .accSigned(accSigned), .addr(addr), .wrData(wrData),
    .memoryOut(memoryOut), .dataValid(dataValid), .stall(stall),
    .misalignErr(misalignErr), .fatalErr(fatalErr),
    .cacheEn(cacheEn), .cacheRd(cacheRd), .cacheWr(cacheWr), .cacheLd(cacheLd),
    .cacheAddr(cacheAddr), .cacheDataIn(cacheDataIn), .cacheByteEn(cacheByteEn),
    .cacheBlkIn(cacheBlkIn), .cacheDataOut(cacheDataOut),
    .cacheHit(cacheHit), .cacheMiss(cacheMiss), .cacheEvict(cacheEvict),
    .cacheBlkOut(cacheBlkOut), .mcEvict(mcEvict), .mcDataOut(mcDataOut),
    .evictDone(evictDone), .mcReq(mcReq), .mcReqAddr(mcReqAddr),
    .mcDataValid(mcDataValid), .mcDataIn(mcDataIn)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic clear_inputs();
    memRead = 0; memWrite = 0; accSize = 2'b10; accSigned = 0;
    addr = '0; wrData = '0; cacheDataOut = '0; cacheHit = 0;
    cacheMiss = 0; cacheEvict = 0; cacheBlkOut = '0; evictDone = 0;
    mcDataValid = 0; mcDataIn = '0;
  endtask

  // Issue a read that hits; returns at the negedge of the dataValid cycle.
  task automatic read_hit(input logic [31:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] d);
    @(posedge clk); #1;
    memRead = 1; addr = a; accSize = sz; accSigned = sg;
    @(posedge clk); #1;
    memRead = 0; cacheHit = 1; cacheMiss = 0; cacheDataOut = d;
    @(posedge clk); #1;
    cacheHit = 0; cacheDataOut = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    memRead = 1; addr = 32'h100; accSize = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall got %0b want 0", stall); else passed++;
    checks++; if (cacheEn !== 1'b0) $display("[TB] FAIL reset_cacheEn got %0b want 0", cacheEn); else passed++;
    checks++; if (memoryOut !== 32'h0) $display("[TB] FAIL reset_memoryOut got %h want 0", memoryOut); else passed++;
    checks++; if ({dataValid, misalignErr, fatalErr, mcReq, mcEvict} !== 5'b0)
      $display("[TB] FAIL reset_flags got %b want 00000", {dataValid, misalignErr, fatalErr, mcReq, mcEvict}); else passed++;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_read_hit();
    @(posedge clk); #1;
    memRead = 1; addr = 32'h104; accSize = 2'b10; accSigned = 0;
    @(negedge clk);
    checks++; if (stall !== 1'b1) $display("[TB] FAIL hit_stall_c0 got %0b want 1", stall); else passed++;
    @(posedge clk); #1;
    memRead = 0; cacheHit = 1; cacheDataOut = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (stall !== 1'b1) $display("[TB] FAIL hit_stall_c1 got %0b want 1", stall); else passed++;
    checks++; if ({cacheEn, cacheRd, cacheWr} !== 3'b110) $display("[TB] FAIL hit_ctrl got %b want 110", {cacheEn, cacheRd, cacheWr}); else passed++;
    checks++; if (cacheAddr !== 32'h104) $display("[TB] FAIL hit_cacheAddr got %h want 104", cacheAddr); else passed++;
    checks++; if (dataValid !== 1'b0) $display("[TB] FAIL hit_dv_early got %0b want 0", dataValid); else passed++;
    @(posedge clk); #1;
    cacheHit = 0; cacheDataOut = '0;
    @(negedge clk);
    checks++; if (dataValid !== 1'b1) $display("[TB] FAIL hit_dv got %0b want 1", dataValid); else passed++;
    checks++; if (memoryOut !== 32'hDEADBEEF) $display("[TB] FAIL hit_data got %h want deadbeef", memoryOut); else passed++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL hit_stall_c2 got %0b want 0", stall); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dataValid !== 1'b0) $display("[TB] FAIL hit_dv_pulse got %0b want 0", dataValid); else passed++;
    checks++; if (memoryOut !== 32'hDEADBEEF) $display("[TB] FAIL hit_hold got %h want deadbeef", memoryOut); else passed++;
  endtask

  task automatic test_signed_read();
    read_hit(32'h103, 2'b00, 1'b1, 32'h8000_0000);
    checks++; if (memoryOut !== 32'hFFFF_FF80) $display("[TB] FAIL sbyte got %h want ffffff80", memoryOut); else passed++;
    read_hit(32'h103, 2'b00, 1'b0, 32'h8000_0000);
    checks++; if (memoryOut !== 32'h0000_0080) $display("[TB] FAIL ubyte got %h want 00000080", memoryOut); else passed++;
    read_hit(32'h102, 2'b01, 1'b1, 32'h8001_1234);
    checks++; if (memoryOut !== 32'hFFFF_8001) $display("[TB] FAIL shalf got %h want ffff8001", memoryOut); else passed++;
    checks++; if (dataValid !== 1'b1) $display("[TB] FAIL shalf_dv got %0b want 1", dataValid); else passed++;
  endtask

  task automatic test_write_evict();
    @(posedge clk); #1;
    memWrite = 1; addr = 32'h2044; accSize = 2'b10; wrData = 32'h1122_3344;
    @(posedge clk); #1;
    memWrite = 0; cacheMiss = 1; cacheEvict = 1; cacheBlkOut = VICTIM;
    @(negedge clk);
    checks++; if ({cacheEn, cacheWr, cacheRd} !== 3'b110) $display("[TB] FAIL wr_ctrl got %b want 110", {cacheEn, cacheWr, cacheRd}); else passed++;
    checks++; if (cacheByteEn !== 4'hF) $display("[TB] FAIL wr_be got %b want 1111", cacheByteEn); else passed++;
    checks++; if (cacheDataIn !== 32'h1122_3344) $display("[TB] FAIL wr_data got %h want 11223344", cacheDataIn); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cacheMiss = 0; cacheEvict = 0;
      @(negedge clk);
      checks++; if (mcEvict !== 1'b1) $display("[TB] FAIL evict_hold%0d got %0b want 1", i, mcEvict); else passed++;
    end
    checks++; if (mcDataOut !== VICTIM) $display("[TB] FAIL evict_data got %h want %h", mcDataOut[31:0], VICTIM[31:0]); else passed++;
    @(posedge clk); #1;
    evictDone = 1;
    @(posedge clk); #1;
    evictDone = 0;
    @(negedge clk);
    checks++; if (mcEvict !== 1'b0) $display("[TB] FAIL evict_drop got %0b want 0", mcEvict); else passed++;
    checks++; if (mcReq !== 1'b1) $display("[TB] FAIL load_req got %0b want 1", mcReq); else passed++;
    checks++; if (mcReqAddr !== 32'h2040) $display("[TB] FAIL load_addr got %h want 2040", mcReqAddr); else passed++;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if ({mcReq, cacheLd} !== 2'b10) $display("[TB] FAIL load_wait got %b want 10", {mcReq, cacheLd}); else passed++;
    @(posedge clk); #1;
    mcDataValid = 1; mcDataIn = FILLBLK;
    @(negedge clk);
    checks++; if ({cacheEn, cacheLd} !== 2'b11) $display("[TB] FAIL fill_ld got %b want 11", {cacheEn, cacheLd}); else passed++;
    checks++; if (cacheBlkIn !== FILLBLK) $display("[TB] FAIL fill_blk got %h want %h", cacheBlkIn[31:0], FILLBLK[31:0]); else passed++;
    @(posedge clk); #1;
    mcDataValid = 0; mcDataIn = '0;
    @(negedge clk);
    checks++; if ({mcReq, cacheLd, stall} !== 3'b001) $display("[TB] FAIL fill_settle got %b want 001", {mcReq, cacheLd, stall}); else passed++;
    @(posedge clk); #1;
    cacheHit = 1;
    @(negedge clk);
    checks++; if (cacheWr !== 1'b1) $display("[TB] FAIL relookup_wr got %0b want 1", cacheWr); else passed++;
    @(posedge clk); #1;
    cacheHit = 0;
    @(negedge clk);
    checks++; if (dataValid !== 1'b1) $display("[TB] FAIL wr_dv got %0b want 1", dataValid); else passed++;
    checks++; if (memoryOut !== 32'hFFFF_8001) $display("[TB] FAIL wr_keeps_out got %h want ffff8001", memoryOut); else passed++;
  endtask

  task automatic test_write_lanes();
    @(posedge clk); #1;
    memWrite = 1; addr = 32'h2046; accSize = 2'b01; wrData = 32'h0000_ABCD;
    @(posedge clk); #1;
    memWrite = 0; cacheHit = 1;
    @(negedge clk);
    checks++; if (cacheByteEn !== 4'b1100) $display("[TB] FAIL half_be got %b want 1100", cacheByteEn); else passed++;
    checks++; if (cacheDataIn !== 32'hABCD_ABCD) $display("[TB] FAIL half_data got %h want abcdabcd", cacheDataIn); else passed++;
    @(posedge clk); #1;
    cacheHit = 0;
    memWrite = 1; addr = 32'h2045; accSize = 2'b00; wrData = 32'h0000_005A;
    @(posedge clk); #1;
    memWrite = 0; cacheHit = 1;
    @(negedge clk);
    checks++; if (cacheByteEn !== 4'b0010) $display("[TB] FAIL byte_be got %b want 0010", cacheByteEn); else passed++;
    checks++; if (cacheDataIn !== 32'h5A5A_5A5A) $display("[TB] FAIL byte_data got %h want 5a5a5a5a", cacheDataIn); else passed++;
    @(posedge clk); #1;
    cacheHit = 0;
    @(negedge clk);
  endtask

  task automatic test_misalign();
    logic [1:0]  sz [3]  = '{2'b01, 2'b10, 2'b11};
    logic [31:0] ad [3]  = '{32'h101, 32'h100, 32'h100};
    logic        both[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      memRead = 1; memWrite = both[i]; addr = ad[i]; accSize = sz[i];
      @(negedge clk);
      checks++; if (stall !== 1'b0) $display("[TB] FAIL mis%0d_stall got %0b want 0", i, stall); else passed++;
      @(posedge clk); #1;
      memRead = 0; memWrite = 0;
      @(negedge clk);
      checks++; if ({misalignErr, cacheEn, stall} !== 3'b100) $display("[TB] FAIL mis%0d_pulse got %b want 100", i, {misalignErr, cacheEn, stall}); else passed++;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({misalignErr, cacheEn} !== 2'b00) $display("[TB] FAIL mis%0d_clear got %b want 00", i, {misalignErr, cacheEn}); else passed++;
    end
  endtask

  task automatic test_retry_exhaust();
    int lookups = 0;
    int fills = 0;
    int dv = 0;
    @(posedge clk); #1;
    memRead = 1; addr = 32'h300; accSize = 2'b10;
    cacheMiss = 1; mcDataValid = 1; mcDataIn = FILLBLK;
    @(posedge clk); #1;
    memRead = 0;
    for (int i = 0; i < 30 && !fatalErr; i++) begin
      @(negedge clk);
      if (cacheEn && cacheRd) lookups++;
      if (cacheLd) fills++;
      if (dataValid) dv++;
    end
    cacheMiss = 0; mcDataValid = 0; mcDataIn = '0;
    checks++; if (fatalErr !== 1'b1) $display("[TB] FAIL fatal_set got %0b want 1", fatalErr); else passed++;
    checks++; if (lookups !== 3) $display("[TB] FAIL retry_lookups got %0d want 3", lookups); else passed++;
    checks++; if (fills !== 2) $display("[TB] FAIL retry_fills got %0d want 2", fills); else passed++;
    checks++; if (dv !== 0) $display("[TB] FAIL retry_dv got %0d want 0", dv); else passed++;
    @(posedge clk); #1;
    memRead = 1; addr = 32'h104; accSize = 2'b10;
    @(negedge clk);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL fatal_ignore_stall got %0b want 0", stall); else passed++;
    @(posedge clk); #1;
    memRead = 0;
    @(negedge clk);
    checks++; if ({cacheEn, misalignErr, fatalErr} !== 3'b001) $display("[TB] FAIL fatal_ignore got %b want 001", {cacheEn, misalignErr, fatalErr}); else passed++;
    #1 rst = 0;
    #1;
    checks++; if (fatalErr !== 1'b0) $display("[TB] FAIL fatal_clear got %0b want 0", fatalErr); else passed++;
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset_mid_load();
    @(posedge clk); #1;
    memRead = 1; addr = 32'h500; accSize = 2'b10;
    @(posedge clk); #1;
    memRead = 0; cacheMiss = 1;
    @(posedge clk); #1;
    cacheMiss = 0;
    @(negedge clk);
    checks++; if (mcReq !== 1'b1) $display("[TB] FAIL midload_req got %0b want 1", mcReq); else passed++;
    #2 rst = 0;
    #1;
    checks++; if ({mcReq, stall, cacheEn} !== 3'b000) $display("[TB] FAIL midload_abort got %b want 000", {mcReq, stall, cacheEn}); else passed++;
    checks++; if (mcReqAddr !== 32'h0) $display("[TB] FAIL midload_addr got %h want 0", mcReqAddr); else passed++;
    checks++; if (memoryOut !== 32'h0) $display("[TB] FAIL midload_out got %h want 0", memoryOut); else passed++;
    @(posedge clk); #1;
    rst = 1;
    read_hit(32'h108, 2'b10, 1'b0, 32'h1234_5678);
    checks++; if ({dataValid, memoryOut} !== {1'b1, 32'h1234_5678}) $display("[TB] FAIL post_reset_read got %0b/%h want 1/12345678", dataValid, memoryOut); else passed++;
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_read_hit();
    test_signed_read();
    test_write_evict();
    test_write_lanes();
    test_misalign();
    test_retry_exhaust();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
